sfifo_axis_reader: RTL

// - Read-side drain for a synchronous FIFO: pops words from the FIFO read

---
 rtl/sfifo_axis_reader.sv | 112 +++++++++++
 1 files changed

// File: rtl/sfifo_axis_reader.sv
// Purpose: drains a synchronous FIFO (async-read head word) onto an AXI-stream master port.
// Latency: FIFO non-empty at a clock edge -> beat registered onto M_AXIS_TVALID/TDATA by that same edge.
// Backpressure: one-entry skid absorbs the beat popped while TREADY is low; with skid full the FIFO is not popped.
//
// Ports:
//   i_clk, i_reset_n          clock (rising edge), asynchronous active-low reset
//   i_enable                  permit FIFO pops; held beats always drain
//   i_pkt_len                 packet length minus one (used only with TLAST generation)
//   i_fifo_empty/i_fifo_data  FIFO read side, head word valid whenever !empty
//   o_fifo_rd                 FIFO pop strobe (depends on registers and FIFO/enable only)
//   M_AXIS_TVALID/TREADY/TDATA/TLAST  AXI-stream master
//   o_busy                    a beat is held in the output or skid register
//
// Build option: define AXIS_READER_TLAST_EN to generate TLAST from i_pkt_len;
// otherwise TLAST is tied low and i_pkt_len is ignored.
module sfifo_axis_reader #(
  parameter int BW    = 8,
  parameter int LGPKT = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_enable,
  input  logic [LGPKT-1:0] i_pkt_len,
  input  logic             i_fifo_empty,
  input  logic [BW-1:0]    i_fifo_data,
  output logic             o_fifo_rd,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [BW-1:0]    M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  output logic             o_busy
);

  logic          skid_valid;
  logic [BW-1:0] skid_data;
  logic          skid_last;
  logic          pop;
  logic          adv;
  logic          pop_last;

  // Pop decision never looks at TREADY: the skid register guarantees room
  // for one more word whenever it is empty.
  assign pop       = i_enable && !i_fifo_empty && !skid_valid;
  assign o_fifo_rd = pop;
  assign adv       = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign o_busy    = M_AXIS_TVALID || skid_valid;

`ifdef AXIS_READER_TLAST_EN
  localparam logic [LGPKT-1:0] CNT_ONE = LGPKT'(1);

  logic [LGPKT-1:0] beat_cnt;
  logic [LGPKT-1:0] pkt_len_q;
  logic [LGPKT-1:0] cur_len;

  // Length is taken live on the first beat of a packet and frozen for the rest.
  assign cur_len  = (beat_cnt == '0) ? i_pkt_len : pkt_len_q;
  assign pop_last = (beat_cnt == cur_len);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      beat_cnt  <= '0;
      pkt_len_q <= '0;
    end else if (pop) begin
      if (beat_cnt == '0)
        pkt_len_q <= i_pkt_len;
      beat_cnt <= pop_last ? '0 : beat_cnt + CNT_ONE;
    end
  end
`else
  logic unused_pkt_len;

  assign pop_last       = 1'b0;
  assign unused_pkt_len = ^i_pkt_len;
`endif

  // Output/skid datapath. The last-beat tag rides along with its word.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_last     <= 1'b0;
    end else if (adv) begin
      if (skid_valid) begin
        // Skid holds the older word, so it goes out first. pop is low here
        // (skid full blocks popping), so the skid simply empties.
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= skid_data;
        M_AXIS_TLAST  <= skid_last;
        skid_valid    <= pop;
        if (pop) begin
          skid_data <= i_fifo_data;
          skid_last <= pop_last;
        end
      end else begin
        M_AXIS_TVALID <= pop;
        if (pop) begin
          M_AXIS_TDATA <= i_fifo_data;
          M_AXIS_TLAST <= pop_last;
        end
      end
    end else if (pop) begin
      // Output stalled: park the word just popped.
      skid_valid <= 1'b1;
      skid_data  <= i_fifo_data;
      skid_last  <= pop_last;
    end
  end

endmodule
